// File: rtl/mfa_count_unit.sv
// Most-frequent-value tracker for Index Compression: counts store-path words per block,
// reports the top value and its count on a read strobe, then clears for the next block.
module mfa_count_unit #(
    parameter int WIDTH_DATA = 32,
    parameter int NUM_ENTRY  = 8,
    parameter int WIDTH_CNT  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_En_MFA,
    input  logic                  I_Valid,
    input  logic [WIDTH_DATA-1:0] I_Data,
    input  logic                  I_Set_SData,
    input  logic                  I_Rd_MFA,
    output logic                  O_Rd_Valid,
    output logic [WIDTH_DATA-1:0] O_MFA_Data,
    output logic [WIDTH_CNT-1:0]  O_MFA_Cnt,
    output logic                  O_MFA_Hit,
    output logic [WIDTH_DATA-1:0] O_SData,
    output logic                  O_Ovf,
    output logic                  O_Busy
);

    localparam int IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
    localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;
    localparam logic [WIDTH_CNT-1:0] CNT_ONE = WIDTH_CNT'(1);

    logic [NUM_ENTRY-1:0]  valid_q, valid_cur, valid_nxt;
    logic [WIDTH_DATA-1:0] data_q [NUM_ENTRY];
    logic [WIDTH_CNT-1:0]  cnt_q  [NUM_ENTRY];
    logic [IDX_W-1:0]      best_idx_q, best_idx_cur, best_idx_nxt;
    logic [WIDTH_CNT-1:0]  best_cnt_q, best_cnt_cur, best_cnt_nxt;
    logic                  en_q, rd_q, ovf_nxt;
    logic                  session_start, rd_req, count_ev;
    logic                  match_any, full;
    logic [IDX_W-1:0]      match_idx, free_idx, upd_idx;
    logic                  upd_en, load_en, ovf_set;
    logic [WIDTH_CNT-1:0]  upd_cnt;
    logic                  rd_hit;
    logic [WIDTH_DATA-1:0] rd_data;

    assign session_start = I_En_MFA & ~en_q;
    assign rd_req        = I_Rd_MFA & ~rd_q;
    assign count_ev      = I_En_MFA & I_Valid & ~I_Set_SData & ~I_Rd_MFA;

    // A word arriving on the session-start cycle is counted into the freshly cleared table.
    assign valid_cur    = session_start ? '0 : valid_q;
    assign best_idx_cur = session_start ? '0 : best_idx_q;
    assign best_cnt_cur = session_start ? '0 : best_cnt_q;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        full      = &valid_cur;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (valid_cur[i] && (data_q[i] == I_Data)) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!valid_cur[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // NOTE: every output of this block is assigned a default first, so no latch is inferred.
    always_comb begin
        upd_en       = 1'b0;
        load_en      = 1'b0;
        ovf_set      = 1'b0;
        upd_idx      = '0;
        upd_cnt      = '0;
        valid_nxt    = valid_cur;
        best_idx_nxt = best_idx_cur;
        best_cnt_nxt = best_cnt_cur;
        ovf_nxt      = session_start ? 1'b0 : O_Ovf;

        if (count_ev) begin
            if (match_any) begin
                if (cnt_q[match_idx] != CNT_MAX) begin
                    upd_en  = 1'b1;
                    upd_idx = match_idx;
                    upd_cnt = cnt_q[match_idx] + CNT_ONE;
                end
            end else if (!full) begin
                upd_en  = 1'b1;
                load_en = 1'b1;
                upd_idx = free_idx;
                upd_cnt = CNT_ONE;
            end else begin
                ovf_set = 1'b1;
            end
        end

        if (load_en) valid_nxt[upd_idx] = 1'b1;
        // Strictly greater: on a tie the value that got there first stays best.
        if (upd_en && (upd_cnt > best_cnt_cur)) begin
            best_idx_nxt = upd_idx;
            best_cnt_nxt = upd_cnt;
        end
        if (ovf_set) ovf_nxt = 1'b1;

        if (rd_req) begin
            valid_nxt    = '0;
            best_idx_nxt = '0;
            best_cnt_nxt = '0;
        end
    end

    // Read result always reflects the table as it stood before this edge.
    assign rd_hit  = |valid_q;
    assign rd_data = rd_hit ? data_q[best_idx_q] : '0;

    // NOTE: the table is small and flop-based, so it is reset along with the control state;
    // sequential state uses non-blocking assignments throughout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            en_q       <= 1'b0;
            rd_q       <= 1'b0;
            O_Rd_Valid <= 1'b0;
            O_MFA_Data <= '0;
            O_MFA_Cnt  <= '0;
            O_MFA_Hit  <= 1'b0;
            O_SData    <= '0;
            O_Ovf      <= 1'b0;
            O_Busy     <= 1'b0;
            for (int i = 0; i < NUM_ENTRY; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            en_q       <= I_En_MFA;
            rd_q       <= I_Rd_MFA;
            valid_q    <= valid_nxt;
            best_idx_q <= best_idx_nxt;
            best_cnt_q <= best_cnt_nxt;
            O_Ovf      <= ovf_nxt;
            O_Busy     <= |valid_nxt;
            O_Rd_Valid <= rd_req;
            if (upd_en) begin
                cnt_q[upd_idx] <= upd_cnt;
                if (load_en) data_q[upd_idx] <= I_Data;
            end
            if (rd_req) begin
                O_MFA_Data <= rd_data;
                O_MFA_Cnt  <= best_cnt_q;
                O_MFA_Hit  <= rd_hit;
            end
            if (I_Set_SData && I_Valid) O_SData <= I_Data;
        end
    end

endmodule

// File: doc/mfa_count_unit.md
Name: mfa_count_unit

Overview:
- Frequency-counting datapath that sits directly downstream of the MFA controller inside CRAM.
- It consumes the controller's enable, shared-data-capture and read strobes, and observes the store-path data words of a block.
- It tracks the most frequently appeared word value for Index Compression.
- On a read strobe it returns that value and its count to the restore path, then clears itself for the next block.

Parameters:
- WIDTH_DATA, 32, data word width.
- NUM_ENTRY, 8, tracking-table entries (distinct values per session).
- WIDTH_CNT, 8, occurrence counter width (saturating).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- I_En_MFA, input, 1, enable counting; driven by controller O_En_MFA.
- I_Valid, input, 1, store-path data word valid.
- I_Data, input, WIDTH_DATA, store-path data word.
- I_Set_SData, input, 1, current valid word is the shared data word (controller O_Set_SData).
- I_Rd_MFA, input, 1, read-out request (controller O_Rd_MFA).
- O_Rd_Valid, output, 1, one-cycle pulse: read result valid.
- O_MFA_Data, output, WIDTH_DATA, most frequent value, held until next read.
- O_MFA_Cnt, output, WIDTH_CNT, its occurrence count.
- O_MFA_Hit, output, 1, at least one word was counted in the session read.
- O_SData, output, WIDTH_DATA, captured shared data word.
- O_Ovf, output, 1, sticky: a new value was dropped because the table was full.
- O_Busy, output, 1, table holds at least one valid entry.

Behaviour:

Reset (reset low, asynchronous):
- All table entries invalid; counters 0; best index 0, best count 0.
- All outputs 0.

Table:
- NUM_ENTRY entries, each {valid, data, cnt}.

Session start:
- The cycle after I_En_MFA rises 0→1, the table, best tracker and O_Ovf are cleared.
- O_SData and the O_MFA_* outputs are not cleared.

Count event: I_En_MFA & I_Valid & ~I_Set_SData & ~I_Rd_MFA.
- Parallel compare against all valid entries.
- Hit: cnt ← cnt+1, saturating at 2^WIDTH_CNT−1.
- Miss with a free entry: the lowest-index free entry is loaded with {1, I_Data, 1}.
- Miss with the table full: word dropped; O_Ovf ← 1 (sticky until session start).

Best tracker:
- Updated in the same clock edge as the count event.
- If the updated entry's new cnt > best count (strictly greater), best ← that entry.
- Ties keep the earlier best, so the first value to reach the top count wins.
- A saturated counter never displaces the best.

Shared data:
- I_Set_SData & I_Valid: O_SData ← I_Data at the next edge.
- That word is not counted.
- I_Set_SData without I_Valid is ignored.

Read:
- On I_Rd_MFA, the next cycle has O_Rd_Valid=1 for exactly one cycle.
- O_MFA_Data/O_MFA_Cnt carry the best entry's data/count as of before the read edge.
- O_MFA_Hit = 1 if any entry is valid.
- Empty table: O_MFA_Data=0, O_MFA_Cnt=0, O_MFA_Hit=0.
- The table and best tracker are cleared in the same edge.
- I_Rd_MFA held for multiple cycles: only the first cycle (rising edge) reads; later cycles are ignored.

Simultaneous events:
- I_Rd_MFA with a count event: read wins; the word is discarded and not counted.
- Session start with I_Rd_MFA: the read result is produced first, then the table is cleared (both resolved in the same edge; result unaffected).
- Count events while I_En_MFA=0: ignored.

Status outputs:
- O_Busy = OR of entry valid bits, registered.

Latency:
- Count to visible best: 1 cycle.
- Read request to O_Rd_Valid: 1 cycle.

Test Plan:
1. Session with words 5,7,5,9,5,7, then I_Rd_MFA → O_Rd_Valid pulse 1 cycle later; O_MFA_Data=5, O_MFA_Cnt=3, O_MFA_Hit=1; O_Busy=0 the following cycle.
2. Tie: words 3,4,4,3, then read → O_MFA_Data=4, O_MFA_Cnt=2 (4 reached count 2 first).
3. With NUM_ENTRY=8, feed 9 distinct values 0..8, then 0 again → O_Ovf=1; value 8 not stored; read gives O_MFA_Data=0, O_MFA_Cnt=2.
4. Word 0xAA with I_Set_SData, then 0xAA, 0xBB, 0xBB → O_SData=0xAA; read gives 0xBB, count 2.
5. Read with no words counted → O_Rd_Valid=1, O_MFA_Hit=0, O_MFA_Data=0, O_MFA_Cnt=0; with WIDTH_CNT=2, value 1 sent 5 times → O_MFA_Cnt=3 (saturated).
6. reset pulled low mid-session after 2 counts, then released; a read then gives O_MFA_Hit=0 and O_Ovf=0. Also: I_Rd_MFA in the same cycle as valid word 6 → 6 is not counted in the next session.
